// File: rtl/uLBC_pkg.sv
// Shared constants, FSM state type and inverse nibble-position table
// for the uLBC-128s permutation engines.
package uLBC_pkg;

  localparam int STATE_W = 128;
  localparam int NIB_N   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // INV_POS[j] = source nibble k, so out_nibble[j] = in_nibble[INV_POS[j]]
  localparam int INV_POS [0:NIB_N-1] = '{
    12, 25, 22,  7,  8, 17, 30,  3,
    16, 21,  2, 15, 24, 29,  6, 11,
    28,  1, 10, 19,  0, 13, 18, 23,
    20,  5, 14, 27,  4,  9, 26, 31
  };

endpackage

// File: rtl/posperm_inv_iter_if.sv
// Request/result handshake bundle for the iterative inverse PosPerm engine.
interface posperm_inv_iter_if
  import uLBC_pkg::*;
#(
  parameter int ROUND_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic [ROUND_W-1:0] in_rounds;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic               abort;
  logic               busy;

  modport master (
    output in_valid, in_data, in_rounds, out_ready, abort,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_rounds, out_ready, abort,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/posperm_inv.sv
// Purely combinational inverse nibble-position permutation of a 128-bit state.
module posperm_inv
  import uLBC_pkg::*;
(
  input  logic [STATE_W-1:0] in_data,
  output logic [STATE_W-1:0] out_data
);

  for (genvar gi = 0; gi < NIB_N; gi++) begin : g_nib
    assign out_data[4*gi +: 4] = in_data[4*INV_POS[gi] +: 4];
  end

endmodule

// File: rtl/posperm_inv_iter.sv
// Iterative inverse PosPerm: accepts a state and round count, applies the
// inverse map once per clock, then presents the result until consumed.
module posperm_inv_iter
  import uLBC_pkg::*;
#(
  parameter int ROUND_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  posperm_inv_iter_if.slave bus
);

  fsm_state_t         state_reg, state_next;
  logic [STATE_W-1:0] data_reg, data_next, data_inv;
  logic [ROUND_W-1:0] cnt_reg, cnt_next;

  posperm_inv u_inv (
    .in_data  (data_reg),
    .out_data (data_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
    end
  end

  // abort wins over both handshakes; the data register is left untouched on abort
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (!bus.abort && bus.in_valid) begin
          data_next  = bus.in_data;
          cnt_next   = bus.in_rounds;
          state_next = (bus.in_rounds == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          data_next = data_inv;
          cnt_next  = cnt_reg - ROUND_W'(1);
          if (cnt_reg == ROUND_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_data  = data_reg;

endmodule

// File: tb/tb_posperm_inv_iter.sv
// Directed self-checking bench for posperm_inv_iter with an independent
// nibble-table model of the inverse and forward PosPerm layers.
module tb_posperm_inv_iter;

  localparam int ROUND_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  posperm_inv_iter_if #(.ROUND_W(ROUND_W)) bus ();

  posperm_inv_iter #(.ROUND_W(ROUND_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Source nibble k for destination j31..j0, as listed in the map definition
  int unsigned k_list [32] = '{31, 26,  9,  4, 27, 14,  5, 20,
                               23, 18, 13,  0, 19, 10,  1, 28,
                               11,  6, 29, 24, 15,  2, 21, 16,
                                3, 30, 17,  8,  7, 22, 25, 12};

  function automatic logic [127:0] model_inv(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[4*j +: 4] = x[4*k_list[31-j] +: 4];
    return y;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[4*k_list[31-j] +: 4] = x[4*j +: 4];
    return y;
  endfunction

  function automatic logic [127:0] model_inv_n(input logic [127:0] x, input int n);
    logic [127:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = model_inv(y);
    return y;
  endfunction

  // Stimulus helper: issue one request from IDLE, wait for the result, consume it
  task automatic do_job(input logic [127:0] d, input logic [ROUND_W-1:0] r,
                        output logic [127:0] res, output int lat);
    bus.in_data   = d;
    bus.in_rounds = r;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.in_rounds = '0;
    bus.out_ready = 1; bus.abort = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_vec++; if (bus.out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: released");
  endtask

  task automatic test_directed();
    logic [127:0] res;
    int lat;
    do_job(128'hFEDCBA9876543210FEDCBA9876543210, 6'd1, res, lat);
    $display("directed r=1: out=%h lat=%0d", res, lat);
    n_vec++; if (res !== 128'hFA94BE5472D03A1CB6D8F2503E18769C) begin n_err++; $display("FAIL directed_data: got %h expected FA94BE5472D03A1CB6D8F2503E18769C", res); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL directed_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_single_nibble();
    logic [127:0] res;
    int lat;
    do_job(128'h1 << 48, 6'd1, res, lat);
    $display("nibble12 r=1: out=%h lat=%0d", res, lat);
    n_vec++; if (res !== 128'h1) begin n_err++; $display("FAIL nibble_r1_data: got %h expected 1", res); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL nibble_r1_latency: got %0d expected 2", lat); end
    do_job(128'h1 << 48, 6'd0, res, lat);
    $display("nibble12 r=0: out=%h lat=%0d", res, lat);
    n_vec++; if (res !== (128'h1 << 48)) begin n_err++; $display("FAIL nibble_r0_data: got %h expected %h", res, 128'h1 << 48); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL nibble_r0_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_round_trip();
    logic [127:0] x, res, back;
    int busy_cnt;
    x = {$urandom, $urandom, $urandom, $urandom};
    res = '0;
    busy_cnt = 0;
    bus.in_data = x; bus.in_rounds = 6'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) res = bus.out_data;
      @(posedge clk); #1;
    end
    back = res;
    for (int i = 0; i < 5; i++) back = model_fwd(back);
    $display("round trip r=5: x=%h out=%h busy=%0d", x, res, busy_cnt);
    n_vec++; if (back !== x) begin n_err++; $display("FAIL roundtrip_fwd: got %h expected %h", back, x); end
    n_vec++; if (res !== model_inv_n(x, 5)) begin n_err++; $display("FAIL roundtrip_model: got %h expected %h", res, model_inv_n(x, 5)); end
    n_vec++; if (busy_cnt !== 6) begin n_err++; $display("FAIL roundtrip_busy_cycles: got %0d expected 6", busy_cnt); end
  endtask

  task automatic test_backpressure();
    logic [127:0] x, exp_d;
    int lat;
    x = 128'h0123456789ABCDEF_FEDCBA9876543210;
    exp_d = model_inv_n(x, 3);
    bus.out_ready = 1'b0;
    bus.in_data = x; bus.in_rounds = 6'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data = ~x;
    bus.in_rounds = 6'd7;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    for (int c = 0; c < 10; c++) begin
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold c%0d: got %b expected 1", c, bus.out_valid); end
      n_vec++; if (bus.out_data !== exp_d) begin n_err++; $display("FAIL bp_data_hold c%0d: got %h expected %h", c, bus.out_data, exp_d); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    $display("backpressure r=3: out=%h lat=%0d released", exp_d, lat);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_abort();
    logic seen_valid;
    bus.in_data = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    bus.in_rounds = 6'd20; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_run_busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL abort_run_in_ready: got %b expected 1", bus.in_ready); end
    seen_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL abort_run_no_result: got %b expected 0", seen_valid); end
    // abort together with a request in IDLE: nothing accepted
    bus.in_rounds = 6'd2; bus.in_valid = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.abort = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_idle_busy: got %b expected 0", bus.busy); end
    // abort in DONE while stalled
    bus.out_ready = 1'b0;
    bus.in_rounds = 6'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL abort_done_setup: got %b expected 1", bus.out_valid); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.out_ready = 1'b1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL abort_done_valid: got %b expected 0", bus.out_valid); end
    $display("abort: run/idle/done cases applied");
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat;
    bus.in_data = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    bus.in_rounds = 6'd20; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_run_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // reset while a result is stalled in DONE
    bus.out_ready = 1'b0;
    bus.in_rounds = 6'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_done_valid: got %b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    do_job(128'hFEDCBA9876543210FEDCBA9876543210, 6'd1, res, lat);
    $display("post-reset r=1: out=%h lat=%0d", res, lat);
    n_vec++; if (res !== 128'hFA94BE5472D03A1CB6D8F2503E18769C) begin n_err++; $display("FAIL rst_next_job: got %h expected FA94BE5472D03A1CB6D8F2503E18769C", res); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [4];
    logic [127:0] e [4];
    int r [4];
    int acc, got, cyc;
    logic prev_ready;
    d = '{128'h0123456789ABCDEF0123456789ABCDEF, 128'h1 << 48,
          128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 128'h13579BDF2468ACE0FDB97531ECA86420};
    r = '{0, 1, 2, 63};
    for (int i = 0; i < 4; i++) e[i] = model_inv_n(d[i], r[i]);
    acc = 0; got = 0; cyc = 0;
    bus.out_ready = 1'b1;
    bus.in_data = d[0]; bus.in_rounds = ROUND_W'(r[0]); bus.in_valid = 1'b1;
    while (got < 4 && cyc < 400) begin
      prev_ready = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (prev_ready && acc < 4) begin
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept%0d: busy got %b expected 1", acc, bus.busy); end
        acc++;
        if (acc < 4) begin
          bus.in_data = d[acc]; bus.in_rounds = ROUND_W'(r[acc]);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        $display("b2b job%0d r=%0d: out=%h", got, r[got], bus.out_data);
        n_vec++; if (bus.out_data !== e[got]) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", got, bus.out_data, e[got]); end
        n_vec++; if (acc !== got + 1) begin n_err++; $display("FAIL b2b_overlap%0d: accepted %0d expected %0d", got, acc, got + 1); end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    n_vec++; if (got !== 4) begin n_err++; $display("FAIL b2b_timeout: results %0d expected 4", got); end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_single_nibble();
    test_round_trip();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
